// File: rtl/a51_key_pkg.sv
// Shared state encoding and PS/2 set-2 control codes for the A5/1 key entry path.
package a51_key_pkg;

  typedef enum logic [1:0] {IDLE, BREAK, EXT, DONE} state_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  localparam int NUM_NIBBLES = 16;

endpackage

// File: rtl/ps2_hex_decode.sv
// Combinational PS/2 set-2 make code to hex nibble map (0-9, A-F).
module ps2_hex_decode (
  input  logic [7:0] scan_code,
  output logic       is_hex,
  output logic [3:0] nibble
);

  always_comb begin
    is_hex = 1'b1;
    nibble = 4'h0;
    case (scan_code)
      8'h45: nibble = 4'h0;
      8'h16: nibble = 4'h1;
      8'h1E: nibble = 4'h2;
      8'h26: nibble = 4'h3;
      8'h25: nibble = 4'h4;
      8'h2E: nibble = 4'h5;
      8'h36: nibble = 4'h6;
      8'h3D: nibble = 4'h7;
      8'h3E: nibble = 4'h8;
      8'h46: nibble = 4'h9;
      8'h1C: nibble = 4'hA;
      8'h32: nibble = 4'hB;
      8'h21: nibble = 4'hC;
      8'h23: nibble = 4'hD;
      8'h24: nibble = 4'hE;
      8'h2B: nibble = 4'hF;
      default: is_hex = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_key_entry.sv
// PS/2 hex key entry feeding the A5/1 key register one nibble per keystroke, MSB first.
// Define KEY_ENTRY_BACKSPACE_EN to let Backspace (66) erase the last nibble, also from DONE.
module ps2_key_entry #(
  parameter int NUM_NIBBLES = 16,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_valid,
  input  logic [7:0]       scan_code,
  output logic [3:0]       ps2data_out,
  output logic [IDX_W-1:0] keyindex,
  output logic             write_enable,
  output logic [4:0]       count,
  output logic             key_full,
  output logic             key_done
);

  import a51_key_pkg::*;

  localparam logic [4:0] FULL_CNT = 5'(NUM_NIBBLES);
  localparam logic [4:0] LAST_IDX = 5'(NUM_NIBBLES - 1);

  state_t     state_reg;
  logic       is_hex;
  logic [3:0] nibble;

  ps2_hex_decode u_decode (
    .scan_code (scan_code),
    .is_hex    (is_hex),
    .nibble    (nibble)
  );

  assign key_full = (count == FULL_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      count        <= 5'd0;
      ps2data_out  <= 4'h0;
      keyindex     <= '0;
      write_enable <= 1'b0;
      key_done     <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      key_done     <= 1'b0;
      if (scan_valid) begin
        case (state_reg)
          IDLE: begin
            if (scan_code == SC_BREAK) begin
              state_reg <= BREAK;
            end else if (scan_code == SC_EXT) begin
              state_reg <= EXT;
            end else if (is_hex) begin
              if (count < FULL_CNT) begin
                write_enable <= 1'b1;
                keyindex     <= IDX_W'(LAST_IDX - count);
                ps2data_out  <= nibble;
                count        <= count + 5'd1;
              end
            end else if (scan_code == SC_ENTER) begin
              if (count == FULL_CNT) begin
                key_done  <= 1'b1;
                state_reg <= DONE;
              end
`ifdef KEY_ENTRY_BACKSPACE_EN
            end else if (scan_code == SC_BKSP) begin
              if (count != 5'd0) begin
                write_enable <= 1'b1;
                keyindex     <= IDX_W'(FULL_CNT - count);
                ps2data_out  <= 4'h0;
                count        <= count - 5'd1;
              end
`endif
            end
          end
          BREAK: state_reg <= IDLE;
          // Extended sequences are dropped entirely, so keypad Enter never completes a key.
          EXT: state_reg <= (scan_code == SC_BREAK) ? BREAK : IDLE;
          DONE: begin
`ifdef KEY_ENTRY_BACKSPACE_EN
            if (scan_code == SC_BKSP && count != 5'd0) begin
              write_enable <= 1'b1;
              keyindex     <= IDX_W'(FULL_CNT - count);
              ps2data_out  <= 4'h0;
              count        <= count - 5'd1;
              state_reg    <= IDLE;
            end
`endif
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_entry.sv
// Directed self-checking bench for ps2_key_entry; honours KEY_ENTRY_BACKSPACE_EN.
module tb_ps2_key_entry;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic [3:0] ps2data_out;
  logic [3:0] keyindex;
  logic       write_enable;
  logic [4:0] count;
  logic       key_full;
  logic       key_done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] hex_codes [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

  always #5 clk = ~clk;

  ps2_key_entry #(.NUM_NIBBLES(16), .IDX_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .scan_valid   (scan_valid),
    .scan_code    (scan_code),
    .ps2data_out  (ps2data_out),
    .keyindex     (keyindex),
    .write_enable (write_enable),
    .count        (count),
    .key_full     (key_full),
    .key_done     (key_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte for one cycle; returns on the falling edge after the registered response.
  task automatic send(input logic [7:0] code);
    @(negedge clk);
    scan_valid = 1'b1;
    scan_code  = code;
    @(negedge clk);
    scan_valid = 1'b0;
    $display("byte %02h: we=%0b idx=%0d data=%0h count=%0d done=%0b",
             code, write_enable, keyindex, ps2data_out, count, key_done);
  endtask

  task automatic send_expect(input string tag, input logic [7:0] code, input logic exp_we,
                             input logic [3:0] exp_idx, input logic [3:0] exp_data);
    send(code);
    check({tag, "_we"}, 32'(write_enable), 32'(exp_we));
    if (exp_we) begin
      check({tag, "_idx"}, 32'(keyindex), 32'(exp_idx));
      check({tag, "_data"}, 32'(ps2data_out), 32'(exp_data));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_we", 32'(write_enable), 0);
    check("rst_count", 32'(count), 0);
    check("rst_idx", 32'(keyindex), 0);
    check("rst_data", 32'(ps2data_out), 0);
    check("rst_full", 32'(key_full), 0);
    check("rst_done", 32'(key_done), 0);
    reset = 1'b0;

    // Keys 1,2,3 each followed by its break sequence
    send_expect("k1", 8'h16, 1'b1, 4'd15, 4'h1);
    send_expect("k1_f0", 8'hF0, 1'b0, 4'd0, 4'h0);
    send_expect("k1_brk", 8'h16, 1'b0, 4'd0, 4'h0);
    send_expect("k2", 8'h1E, 1'b1, 4'd14, 4'h2);
    send_expect("k2_f0", 8'hF0, 1'b0, 4'd0, 4'h0);
    send_expect("k2_brk", 8'h1E, 1'b0, 4'd0, 4'h0);
    send_expect("k3", 8'h26, 1'b1, 4'd13, 4'h3);
    send_expect("k3_f0", 8'hF0, 1'b0, 4'd0, 4'h0);
    send_expect("k3_brk", 8'h26, 1'b0, 4'd0, 4'h0);
    check("count3", 32'(count), 3);

    // Unmapped code and a lone break prefix swallowing a hex key
    send_expect("space", 8'h29, 1'b0, 4'd0, 4'h0);
    send_expect("lone_f0", 8'hF0, 1'b0, 4'd0, 4'h0);
    send_expect("lone_1c", 8'h1C, 1'b0, 4'd0, 4'h0);
    check("count_unch", 32'(count), 3);

`ifdef KEY_ENTRY_BACKSPACE_EN
    send_expect("bksp", 8'h66, 1'b1, 4'd13, 4'h0);
    check("bksp_count", 32'(count), 2);
    send_expect("after_bksp", 8'h32, 1'b1, 4'd13, 4'hB);
    check("after_bksp_count", 32'(count), 3);
`else
    send_expect("bksp_ign", 8'h66, 1'b0, 4'd0, 4'h0);
    check("bksp_ign_count", 32'(count), 3);
    send_expect("after_bksp", 8'h32, 1'b1, 4'd12, 4'hB);
    check("after_bksp_count", 32'(count), 4);
`endif

    // Reset while in BREAK after 5 nibbles
    do_reset();
    for (int i = 0; i < 5; i++)
      send_expect($sformatf("pre%0d", i), hex_codes[i], 1'b1, 4'(15 - i), 4'(i));
    @(negedge clk);
    scan_valid = 1'b1;
    scan_code  = 8'hF0;
    @(posedge clk);
    #1 reset = 1'b1;
    scan_valid = 1'b0;
    #1;
    check("async_count", 32'(count), 0);
    check("async_idx", 32'(keyindex), 0);
    check("async_data", 32'(ps2data_out), 0);
    @(negedge clk);
    reset = 1'b0;
    send_expect("post_rst", 8'h45, 1'b1, 4'd15, 4'h0);

    // Full 16-nibble key; the first two bytes arrive back-to-back
    do_reset();
    @(negedge clk);
    scan_valid = 1'b1;
    scan_code  = hex_codes[0];
    @(negedge clk);
    scan_code  = hex_codes[1];
    check("b2b0_we", 32'(write_enable), 1);
    check("b2b0_idx", 32'(keyindex), 15);
    check("b2b0_data", 32'(ps2data_out), 0);
    @(negedge clk);
    scan_valid = 1'b0;
    check("b2b1_we", 32'(write_enable), 1);
    check("b2b1_idx", 32'(keyindex), 14);
    check("b2b1_data", 32'(ps2data_out), 1);
    for (int i = 2; i < 16; i++) begin
      send_expect($sformatf("nib%0d", i), hex_codes[i], 1'b1, 4'(15 - i), 4'(i));
      check($sformatf("full%0d", i), 32'(key_full), (i == 15) ? 1 : 0);
    end
    check("count16", 32'(count), 16);

    send("E0");
    send(8'hE0);
    check("kp_e0_done", 32'(key_done), 0);
    send(8'h5A);
    check("kp_enter_done", 32'(key_done), 0);
    send(8'hE0);
    send(8'hF0);
    send(8'h5A);
    check("kp_brk_done", 32'(key_done), 0);
    send_expect("nib17", 8'h45, 1'b0, 4'd0, 4'h0);
    check("count_hold", 32'(count), 16);
    send(8'h5A);
    check("enter_done", 32'(key_done), 1);
    @(negedge clk);
    check("done_pulse", 32'(key_done), 0);
    send_expect("in_done", 8'h16, 1'b0, 4'd0, 4'h0);
    send(8'h5A);
    check("done_terminal", 32'(key_done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
